mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the registered ALU result, destination register and write-back enable. For loads and stores it uses the ALU result as the data-memory address.
- Runs a req/ready handshake with data memory, aligns and extends load data, builds store byte strobes, and registers the result toward write-back.
- Stalls the pipeline while memory is busy.

Parameters:
- ADDR_WIDTH, 32, width of dm_addr; taken from the low bits of alu_out_mem.
- STALL_CNT_WIDTH, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_op_mem  in  2  00 none, 01 load, 10 store, 11 treated as none.
- funct3_mem  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_out_mem  in  32  ALU result, or memory address for loads/stores.
- store_data_mem  in  32  rs2 value for stores.
- rd_addr_mem  in  5  destination register.
- wb_en_mem  in  1  register write enable.
- dm_req  out  1  memory request.
- dm_we  out  4  byte write strobes; 0000 means read.
- dm_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 00).
- dm_wdata  out  32  lane-replicated store data.
- dm_rdata  in  32  read data, valid when dm_ready=1.
- dm_ready  in  1  completes the current request.
- stall_mem  out  1  freeze IF/ID/EX and this stage's inputs.
- rd_addr_wb  out  5  registered destination.
- wb_en_wb  out  1  registered write enable.
- wb_data_wb  out  32  registered write-back data; also the forward source to EX.
- stall_cycles  out  STALL_CNT_WIDTH  saturating count of stall_mem=1 cycles.

Behaviour:
- Reset values: all outputs 0 (rd_addr_wb, wb_en_wb, wb_data_wb, stall_cycles); FSM returns to IDLE.
- Reset mid-transaction: dm_req drops in the same cycle; the pending access is abandoned and no write-back occurs.
- FSM states: IDLE, WAIT.
- IDLE with mem_op none/11:
  - No request.
  - Next edge: rd_addr_wb←rd_addr_mem, wb_en_wb←wb_en_mem, wb_data_wb←alu_out_mem.
  - Latency is 1 cycle.
- IDLE with load or store:
  - dm_req=1 combinationally, with addr/we/wdata driven from the current inputs.
  - dm_ready=1 in the same cycle: access completes and write-back registers update at that edge (1 cycle); stay in IDLE.
  - dm_ready=0: go to WAIT.
- WAIT:
  - dm_req=1, with addr/we/wdata held stable; upstream guarantees the *_mem inputs are stable while stall_mem=1.
  - On dm_ready=1: complete, then go to IDLE.
- stall_mem = dm_req & ~dm_ready (combinational).
- While stalled, write-back registers load a bubble: wb_en_wb=0; rd_addr_wb and wb_data_wb hold.
- Store strobes:
  - SB: dm_we = 0001 << addr[1:0]; dm_wdata = byte replicated ×4.
  - SH: dm_we = 0011 << (2·addr[1]); dm_wdata = half replicated ×2.
  - SW: dm_we = 1111; dm_wdata = store_data_mem.
- Loads (dm_we=0000):
  - Byte selected by addr[1:0]; half selected by addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Undefined load funct3 is treated as W.
- Store completion writes wb_en_wb←wb_en_mem (0 by decode contract) and wb_data_wb←alu_out_mem.
- stall_cycles increments on every stall_mem=1 cycle and saturates at all-ones; it never wraps.
- A back-to-back access in the cycle after completion starts a fresh handshake from IDLE.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Adds output misalign_trap (1 bit, reset 0).
  - H/HU with addr[0]=1, or W with addr[1:0]≠00, issues no dm_req and causes no stall.
  - Next edge: misalign_trap=1 for one cycle, wb_en_wb=0.
- Undefined:
  - Low address bits are ignored for alignment: W uses the aligned word; H uses addr[1] only.
  - No port is added.

Decomposition:
- Package mem_stage_pkg holds:
  - mem_op_e enum (MEM_NONE, MEM_LOAD, MEM_STORE).
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - state_e (IDLE, WAIT).
- One sub-module, load_align: combinational; inputs rdata, addr[1:0], funct3; output the extended 32-bit value. It is reusable by a future D-cache.

Test Plan:
- ALU pass-through: op=none, alu_out_mem=0x0000_1234, rd=5, wb_en=1 → next cycle wb_data_wb=0x1234, rd_addr_wb=5, wb_en_wb=1, dm_req never asserted.
- Zero-wait LB: addr=0x103, dm_rdata=0x80FF_0000, ready same cycle → wb_data_wb=0xFFFF_FF80, stall_mem never 1.
- LHU with 3 wait states: addr=0x102, dm_rdata=0xBEEF_0000 → stall_mem=1 for 3 cycles, 3 bubbles (wb_en_wb=0), then wb_data_wb=0x0000_BEEF; stall_cycles=3.
- SB/SH strobes: SB addr=0x201 data=0xAB → dm_we=0010, dm_wdata=0xABAB_ABAB. SH addr=0x202 data=0x1234 → dm_we=1100, dm_wdata=0x1234_1234.
- Reset during WAIT: assert rst in the 2nd wait cycle → dm_req=0 immediately, all outputs 0, FSM in IDLE, no write-back after release.
- MISALIGN_TRAP_EN defined, LW addr=0x301 → no dm_req, misalign_trap pulses 1 cycle, wb_en_wb=0. Undefined: dm_addr=0x300 and the load completes normally.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// +------------------------------------------------------------------+
// | mem_stage_pkg : shared types and constants for the memory stage  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

package mem_stage_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/mem_stage_load_align.sv
// +------------------------------------------------------------------+
// | load_align : selects and extends load data from a 32-bit word    |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr)
      2'b00:   byte_sel = rdata[7:0];
      2'b01:   byte_sel = rdata[15:8];
      2'b10:   byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  // Unknown encodings fall through to a full-word load.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// +------------------------------------------------------------------+
// | mem_stage : data-memory handshake, load/store alignment, WB regs |
// | Optional: MISALIGN_TRAP_EN adds misalign_trap. Revision 1.0      |
// +------------------------------------------------------------------+
`default_nettype none

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 mem_op_mem,
  input  logic [2:0]                 funct3_mem,
  input  logic [31:0]                alu_out_mem,
  input  logic [31:0]                store_data_mem,
  input  logic [4:0]                 rd_addr_mem,
  input  logic                       wb_en_mem,
  output logic                       dm_req,
  output logic [3:0]                 dm_we,
  output logic [ADDR_WIDTH-1:0]      dm_addr,
  output logic [31:0]                dm_wdata,
  input  logic [31:0]                dm_rdata,
  input  logic                       dm_ready,
  output logic                       stall_mem,
  output logic [4:0]                 rd_addr_wb,
  output logic                       wb_en_wb,
  output logic [31:0]                wb_data_wb,
`ifdef MISALIGN_TRAP_EN
  output logic                       misalign_trap,
`endif
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  state_e      state;
  logic        is_load;
  logic        is_store;
  logic        is_access;
  logic        is_byte;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic [31:0] load_data;
  logic [31:0] wb_next_data;

  assign is_load   = (mem_op_mem == MEM_LOAD);
  assign is_store  = (mem_op_mem == MEM_STORE);
  assign is_access = is_load | is_store;

  // Access size comes from funct3[1:0]; BU/HU share encodings with B/H.
  assign is_byte = (funct3_mem[1:0] == 2'b00);
  assign is_half = (funct3_mem[1:0] == 2'b01);
  assign is_word = ~is_byte & ~is_half;

`ifdef MISALIGN_TRAP_EN
  assign misaligned = is_access & ((is_half & alu_out_mem[0]) |
                                   (is_word & (alu_out_mem[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Gated by rst so an abandoned request drops in the reset cycle itself.
  assign dm_req    = ~rst & ((state == WAIT) | (is_access & ~misaligned));
  assign stall_mem = dm_req & ~dm_ready;
  assign dm_addr   = {alu_out_mem[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    dm_we    = 4'b0000;
    dm_wdata = store_data_mem;
    if (is_byte) begin
      dm_wdata = {4{store_data_mem[7:0]}};
    end else if (is_half) begin
      dm_wdata = {2{store_data_mem[15:0]}};
    end
    if (dm_req && is_store) begin
      if (is_byte) begin
        dm_we = 4'b0001 << alu_out_mem[1:0];
      end else if (is_half) begin
        dm_we = alu_out_mem[1] ? 4'b1100 : 4'b0011;
      end else begin
        dm_we = 4'b1111;
      end
    end
  end

  load_align u_load_align (
    .rdata  (dm_rdata),
    .addr   (alu_out_mem[1:0]),
    .funct3 (funct3_mem),
    .data   (load_data)
  );

  assign wb_next_data = is_load ? load_data : alu_out_mem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      rd_addr_wb   <= 5'd0;
      wb_en_wb     <= 1'b0;
      wb_data_wb   <= 32'd0;
      stall_cycles <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_trap <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:    if (dm_req && !dm_ready) state <= WAIT;
        WAIT:    if (dm_ready) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (stall_mem) begin
        wb_en_wb <= 1'b0;
      end else begin
        rd_addr_wb <= rd_addr_mem;
        wb_en_wb   <= wb_en_mem & ~misaligned;
        wb_data_wb <= wb_next_data;
      end

      if (stall_mem && (stall_cycles != {STALL_CNT_WIDTH{1'b1}})) begin
        stall_cycles <= stall_cycles + 1'b1;
      end

`ifdef MISALIGN_TRAP_EN
      misalign_trap <= misaligned & ~stall_mem;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// +------------------------------------------------------------------+
// | tb_mem_stage : scoreboard testbench for mem_stage                |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_mem_stage;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_RSVD  = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mem_op_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] alu_out_mem;
  logic [31:0] store_data_mem;
  logic [4:0]  rd_addr_mem;
  logic        wb_en_mem;
  logic        dm_req;
  logic [3:0]  dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        stall_mem;
  logic [4:0]  rd_addr_wb;
  logic        wb_en_wb;
  logic [31:0] wb_data_wb;
  logic [15:0] stall_cycles;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_trap;
`endif

  always #5 clk = ~clk;

  mem_stage #(.ADDR_WIDTH(32), .STALL_CNT_WIDTH(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_op_mem     (mem_op_mem),
    .funct3_mem     (funct3_mem),
    .alu_out_mem    (alu_out_mem),
    .store_data_mem (store_data_mem),
    .rd_addr_mem    (rd_addr_mem),
    .wb_en_mem      (wb_en_mem),
    .dm_req         (dm_req),
    .dm_we          (dm_we),
    .dm_addr        (dm_addr),
    .dm_wdata       (dm_wdata),
    .dm_rdata       (dm_rdata),
    .dm_ready       (dm_ready),
    .stall_mem      (stall_mem),
    .rd_addr_wb     (rd_addr_wb),
    .wb_en_wb       (wb_en_wb),
    .wb_data_wb     (wb_data_wb),
`ifdef MISALIGN_TRAP_EN
    .misalign_trap  (misalign_trap),
`endif
    .stall_cycles   (stall_cycles)
  );

  typedef struct {
    logic [4:0]  rd;
    logic        en;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_stall = 16'd0;

  // Drives one instruction, holds it for 'waits' stall cycles, then completes.
  task automatic run_access(input string name, input logic [1:0] op, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] sd,
                            input logic [4:0] rd, input logic wen,
                            input logic [31:0] rdata, input int waits,
                            input logic [31:0] exp_data, input logic exp_req,
                            input logic [3:0] exp_we, input logic [31:0] exp_wdata);
    exp_t e;
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    sb.push_back('{rd, wen, exp_data});
    mem_op_mem = op; funct3_mem = f3; alu_out_mem = addr; store_data_mem = sd;
    rd_addr_mem = rd; wb_en_mem = wen; dm_rdata = rdata;
    for (int w = 0; w < waits; w++) begin
      dm_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (dm_req !== 1'b1 || stall_mem !== 1'b1) begin
        errors++;
        $display("FAIL %s wait%0d req/stall: got %b/%b want 1/1", name, w, dm_req, stall_mem);
      end
      checks++;
      if (dm_addr !== exp_addr) begin
        errors++;
        $display("FAIL %s wait%0d dm_addr: got %h want %h", name, w, dm_addr, exp_addr);
      end
      @(posedge clk); #1;
      exp_stall++;
      checks++;
      if (wb_en_wb !== 1'b0) begin
        errors++;
        $display("FAIL %s bubble%0d wb_en_wb: got %b want 0", name, w, wb_en_wb);
      end
      checks++;
      if (stall_cycles !== exp_stall) begin
        errors++;
        $display("FAIL %s wait%0d stall_cycles: got %0d want %0d", name, w, stall_cycles, exp_stall);
      end
    end
    dm_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (dm_req !== exp_req || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL %s done req/stall: got %b/%b want %b/0", name, dm_req, stall_mem, exp_req);
    end
    if (exp_req) begin
      checks++;
      if (dm_addr !== exp_addr || dm_we !== exp_we) begin
        errors++;
        $display("FAIL %s addr/we: got %h/%b want %h/%b", name, dm_addr, dm_we, exp_addr, exp_we);
      end
      if (exp_we != 4'b0000) begin
        checks++;
        if (dm_wdata !== exp_wdata) begin
          errors++;
          $display("FAIL %s dm_wdata: got %h want %h", name, dm_wdata, exp_wdata);
        end
      end
    end
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++;
    if (rd_addr_wb !== e.rd || wb_en_wb !== e.en || wb_data_wb !== e.data) begin
      errors++;
      $display("FAIL %s wb rd/en/data: got %0d/%b/%h want %0d/%b/%h",
               name, rd_addr_wb, wb_en_wb, wb_data_wb, e.rd, e.en, e.data);
    end
    checks++;
    if (stall_cycles !== exp_stall) begin
      errors++;
      $display("FAIL %s stall_cycles: got %0d want %0d", name, stall_cycles, exp_stall);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    mem_op_mem = OP_NONE; funct3_mem = 3'b000; alu_out_mem = 32'h0; store_data_mem = 32'h0;
    rd_addr_mem = 5'd0; wb_en_mem = 1'b0; dm_rdata = 32'h0; dm_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dm_req !== 1'b0 || stall_mem !== 1'b0 || rd_addr_wb !== 5'd0 || wb_en_wb !== 1'b0 ||
        wb_data_wb !== 32'd0 || stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL reset_values: got req=%b stall=%b rd=%0d en=%b data=%h cnt=%0d want all 0",
               dm_req, stall_mem, rd_addr_wb, wb_en_wb, wb_data_wb, stall_cycles);
    end
`ifdef MISALIGN_TRAP_EN
    checks++;
    if (misalign_trap !== 1'b0) begin
      errors++;
      $display("FAIL reset_trap: got %b want 0", misalign_trap);
    end
`endif
    rst = 1'b0;
    exp_stall = 16'd0;
  endtask

  task automatic test_passthrough;
    run_access("alu_pass", OP_NONE, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1,
               32'h0, 0, 32'h0000_1234, 1'b0, 4'b0000, 32'h0);
    run_access("op11_pass", OP_RSVD, 3'b010, 32'h0000_0777, 32'h0, 5'd6, 1'b1,
               32'h0, 0, 32'h0000_0777, 1'b0, 4'b0000, 32'h0);
  endtask

  task automatic test_loads;
    run_access("lb_zero_wait", OP_LOAD, 3'b000, 32'h0000_0103, 32'h0, 5'd1, 1'b1,
               32'h80FF_0000, 0, 32'hFFFF_FF80, 1'b1, 4'b0000, 32'h0);
    run_access("lhu_3wait", OP_LOAD, 3'b101, 32'h0000_0102, 32'h0, 5'd2, 1'b1,
               32'hBEEF_0000, 3, 32'h0000_BEEF, 1'b1, 4'b0000, 32'h0);
    run_access("lbu", OP_LOAD, 3'b100, 32'h0000_0101, 32'h0, 5'd3, 1'b1,
               32'h0000_C300, 1, 32'h0000_00C3, 1'b1, 4'b0000, 32'h0);
    run_access("lh_low", OP_LOAD, 3'b001, 32'h0000_0100, 32'h0, 5'd4, 1'b1,
               32'h1111_9001, 0, 32'hFFFF_9001, 1'b1, 4'b0000, 32'h0);
  endtask

  task automatic test_stores;
    run_access("sb", OP_STORE, 3'b000, 32'h0000_0201, 32'h0000_00AB, 5'd0, 1'b0,
               32'h0, 0, 32'h0000_0201, 1'b1, 4'b0010, 32'hABAB_ABAB);
    run_access("sh", OP_STORE, 3'b001, 32'h0000_0202, 32'h0000_1234, 5'd0, 1'b0,
               32'h0, 2, 32'h0000_0202, 1'b1, 4'b1100, 32'h1234_1234);
  endtask

  task automatic test_back_to_back;
    run_access("b2b_lw", OP_LOAD, 3'b010, 32'h0000_0104, 32'h0, 5'd10, 1'b1,
               32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b1, 4'b0000, 32'h0);
    run_access("b2b_lh", OP_LOAD, 3'b001, 32'h0000_0106, 32'h0, 5'd11, 1'b1,
               32'h8001_0000, 1, 32'hFFFF_8001, 1'b1, 4'b0000, 32'h0);
    run_access("b2b_sw", OP_STORE, 3'b010, 32'h0000_0108, 32'hCAFE_F00D, 5'd0, 1'b0,
               32'h0, 2, 32'h0000_0108, 1'b1, 4'b1111, 32'hCAFE_F00D);
  endtask

  task automatic test_misalign;
`ifdef MISALIGN_TRAP_EN
    mem_op_mem = OP_LOAD; funct3_mem = 3'b010; alu_out_mem = 32'h0000_0301;
    rd_addr_mem = 5'd9; wb_en_mem = 1'b1; dm_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (dm_req !== 1'b0 || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL trap_no_req: got req=%b stall=%b want 0/0", dm_req, stall_mem);
    end
    @(posedge clk); #1;
    checks++;
    if (misalign_trap !== 1'b1 || wb_en_wb !== 1'b0) begin
      errors++;
      $display("FAIL trap_pulse: got trap=%b en=%b want 1/0", misalign_trap, wb_en_wb);
    end
    mem_op_mem = OP_NONE; wb_en_mem = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (misalign_trap !== 1'b0) begin
      errors++;
      $display("FAIL trap_one_cycle: got %b want 0", misalign_trap);
    end
    dm_ready = 1'b1;
`else
    run_access("lw_misalign", OP_LOAD, 3'b010, 32'h0000_0301, 32'h0, 5'd9, 1'b1,
               32'h1122_3344, 0, 32'h1122_3344, 1'b1, 4'b0000, 32'h0);
`endif
  endtask

  task automatic test_reset_in_wait;
    mem_op_mem = OP_LOAD; funct3_mem = 3'b010; alu_out_mem = 32'h0000_0400;
    rd_addr_mem = 5'd7; wb_en_mem = 1'b1; dm_rdata = 32'h5555_AAAA; dm_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dm_req !== 1'b0 || stall_mem !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_req: got req=%b stall=%b want 0/0", dm_req, stall_mem);
    end
    checks++;
    if (rd_addr_wb !== 5'd0 || wb_en_wb !== 1'b0 || wb_data_wb !== 32'd0 || stall_cycles !== 16'd0) begin
      errors++;
      $display("FAIL rst_wait_outs: got rd=%0d en=%b data=%h cnt=%0d want 0", rd_addr_wb, wb_en_wb,
               wb_data_wb, stall_cycles);
    end
    mem_op_mem = OP_NONE; wb_en_mem = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_stall = 16'd0;
    @(negedge clk);
    checks++;
    if (dm_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_idle: got dm_req=%b want 0", dm_req);
    end
    dm_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (wb_en_wb !== 1'b0) begin
      errors++;
      $display("FAIL rst_wait_no_wb: got wb_en_wb=%b want 0", wb_en_wb);
    end
  endtask

  task automatic test_saturation;
    mem_op_mem = OP_LOAD; funct3_mem = 3'b010; alu_out_mem = 32'h0000_0500;
    rd_addr_mem = 5'd12; wb_en_mem = 1'b1; dm_ready = 1'b0;
    repeat (65540) @(posedge clk);
    #1;
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      errors++;
      $display("FAIL stall_saturate: got %h want ffff", stall_cycles);
    end
    dm_ready = 1'b1;
    @(posedge clk); #1;
    mem_op_mem = OP_NONE; wb_en_mem = 1'b0;
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      errors++;
      $display("FAIL stall_hold: got %h want ffff", stall_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_loads();
    test_stores();
    test_back_to_back();
    test_misalign();
    test_reset_in_wait();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
